// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU load/store path.
//   - request size codes (byte / halfword / word / illegal)
//   - bit positions inside the 4-bit RAM control bus
//   - memory_interface FSM state encoding
package cpu_pkg;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeBad  = 2'b11;

  localparam int unsigned CtlWe       = 0;
  localparam int unsigned CtlByte     = 1;
  localparam int unsigned CtlHalf     = 2;
  localparam int unsigned CtlUnsigned = 3;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StFetch = 3'd2,
    StWrite = 3'd3,
    StResp  = 3'd4
  } state_e;

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a right-aligned load result.
// Ports:
//   data_i        - raw data, sub-word values right-aligned at bit 0
//   size_i        - size code (cpu_pkg Size*)
//   is_unsigned_i - 1: zero-extend, 0: sign-extend (ignored for words)
//   result_o      - extended 32-bit value
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        is_unsigned_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = data_i;
    case (size_i)
      SizeByte: result_o = {{24{~is_unsigned_i & data_i[7]}}, data_i[7:0]};
      SizeHalf: result_o = {{16{~is_unsigned_i & data_i[15]}}, data_i[15:0]};
      default:  result_o = data_i;
    endcase
  end

endmodule

// File: rtl/memory_interface.sv
// Load/store front end between the CPU datapath and a word-organised data RAM.
// One request at a time over valid/ready; alignment, size and range checked at
// acceptance. Sub-word stores do a read-modify-write; loads are extended.
// Ports:
//   clock, reset_n           - clock, async active-low reset
//   req_valid / req_ready    - request handshake (ready only in idle)
//   req_write, req_size,
//   req_unsigned,
//   req_address,
//   req_write_data           - request fields, latched at acceptance
//   resp_valid               - one-cycle response pulse
//   resp_error, resp_data    - response qualifiers
//   ram_control              - [0] we, [1] byte, [2] half, [3] unsigned
//   ram_address,
//   ram_write_data           - RAM address / write data
//   ram_read_data            - combinational RAM read data
module memory_interface
  import cpu_pkg::*;
#(
  parameter int unsigned RAM_WORDS     = 4096,
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [31:0]              req_write_data,
  output logic                     resp_valid,
  output logic                     resp_error,
  output logic [31:0]              resp_data,
  output logic [3:0]               ram_control,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [31:0]              ram_write_data,
  input  logic [31:0]              ram_read_data
);

  state_e                   state_q, state_d;
  logic                     unsigned_q, unsigned_d;
  logic [1:0]               size_q, size_d;
  logic [1:0]               offset_q, offset_d;
  logic [31:0]              data_q, data_d;
  logic                     err_q, err_d;
  logic [31:0]              resp_data_q, resp_data_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]              ram_wdata_q, ram_wdata_d;

  logic                     req_err;
  logic [31:0]              ext_data;
  logic [31:0]              merged;

  // Checks are ordered by priority, but all of them lead to the same error response.
  always_comb begin
    req_err = 1'b0;
    if (req_size == SizeBad) begin
      req_err = 1'b1;
    end else if (req_size == SizeHalf && req_address[0]) begin
      req_err = 1'b1;
    end else if (req_size == SizeWord && req_address[1:0] != 2'b00) begin
      req_err = 1'b1;
    end else if ({2'b00, req_address[ADDRESS_WIDTH-1:2]} >= ADDRESS_WIDTH'(RAM_WORDS)) begin
      req_err = 1'b1;
    end
  end

  load_extend u_load_extend (
    .data_i        (ram_read_data),
    .size_i        (size_q),
    .is_unsigned_i (unsigned_q),
    .result_o      (ext_data)
  );

  // Lane merge of the fetched word with the store data.
  always_comb begin
    merged = ram_read_data;
    if (size_q == SizeByte) begin
      merged[{offset_q, 3'b000} +: 8] = data_q[7:0];
    end else if (offset_q[1]) begin
      merged[31:16] = data_q[15:0];
    end else begin
      merged[15:0] = data_q[15:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    unsigned_d  = unsigned_q;
    size_d      = size_q;
    offset_d    = offset_q;
    data_d      = data_q;
    err_d       = err_q;
    resp_data_d = resp_data_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          unsigned_d  = req_unsigned;
          size_d      = req_size;
          offset_d    = req_address[1:0];
          data_d      = req_write_data;
          err_d       = req_err;
          resp_data_d = '0;
          if (req_err) begin
            // RAM address is left untouched; no RAM access on errors.
            state_d = StResp;
          end else if (!req_write) begin
            ram_addr_d = req_address;
            state_d    = StLoad;
          end else begin
            ram_addr_d = {req_address[ADDRESS_WIDTH-1:2], 2'b00};
            if (req_size == SizeWord) begin
              ram_wdata_d = req_write_data;
              state_d     = StWrite;
            end else begin
              state_d = StFetch;
            end
          end
        end
      end
      StLoad: begin
        resp_data_d = ext_data;
        state_d     = StResp;
      end
      StFetch: begin
        ram_wdata_d = merged;
        state_d     = StWrite;
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      unsigned_q  <= 1'b0;
      size_q      <= 2'b00;
      offset_q    <= 2'b00;
      data_q      <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      unsigned_q  <= unsigned_d;
      size_q      <= size_d;
      offset_q    <= offset_d;
      data_q      <= data_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Control is decoded from the state register, so an async reset during WRITE
  // removes write_enable immediately.
  always_comb begin
    ram_control = 4'b0000;
    unique case (state_q)
      StLoad: begin
        ram_control[CtlByte]     = (size_q == SizeByte);
        ram_control[CtlHalf]     = (size_q == SizeHalf);
        ram_control[CtlUnsigned] = unsigned_q;
      end
      StWrite: ram_control[CtlWe] = 1'b1;
      default: ram_control = 4'b0000;
    endcase
  end

  assign req_ready      = (state_q == StIdle);
  assign resp_valid     = (state_q == StResp);
  assign resp_error     = resp_valid & err_q;
  assign resp_data      = resp_valid ? resp_data_q : 32'h0;
  assign ram_address    = ram_addr_q;
  assign ram_write_data = ram_wdata_q;

endmodule

// File: tb/tb_memory_interface.sv
module tb_memory_interface;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_data;
  logic [3:0]  ram_control;
  logic [31:0] ram_address;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;

  memory_interface #(
    .RAM_WORDS     (4096),
    .ADDRESS_WIDTH (32)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .resp_valid     (resp_valid),
    .resp_error     (resp_error),
    .resp_data      (resp_data),
    .ram_control    (ram_control),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM environment: combinational read, sub-word results zero-extended at bit 0.
  logic [31:0] mem [0:4095];
  logic [31:0] rd_word;
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_val;
  int          we_cnt;

  assign rd_word = mem[ram_address[13:2]];

  always_comb begin
    if (ram_control[1]) begin
      case (ram_address[1:0])
        2'd0:    ram_read_data = {24'h0, rd_word[7:0]};
        2'd1:    ram_read_data = {24'h0, rd_word[15:8]};
        2'd2:    ram_read_data = {24'h0, rd_word[23:16]};
        default: ram_read_data = {24'h0, rd_word[31:24]};
      endcase
    end else if (ram_control[2]) begin
      ram_read_data = ram_address[1] ? {16'h0, rd_word[31:16]} : {16'h0, rd_word[15:0]};
    end else begin
      ram_read_data = rd_word;
    end
  end

  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (ram_control[0]) mem[ram_address[13:2]] <= ram_write_data;
  end

  initial we_cnt = 0;
  always @(negedge clock) if (ram_control[0]) we_cnt <= we_cnt + 1;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
    int          we;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] val);
    @(negedge clock);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(negedge clock);
    pl_en  = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic un, input logic [31:0] addr, input logic [31:0] wd,
                        input logic eerr, input logic [31:0] edata, input int elat,
                        input int ewe);
    exp_t e;
    exp_t got;
    int   lat;
    int   we_base;
    e.err  = eerr;
    e.data = edata;
    e.lat  = elat;
    e.we   = ewe;
    sb.push_back(e);
    @(negedge clock);
    check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    we_base        = we_cnt;
    req_valid      = 1'b1;
    req_write      = wr;
    req_size       = sz;
    req_unsigned   = un;
    req_address    = addr;
    req_write_data = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clock);
      #1;
      lat++;
    end
    got = sb.pop_front();
    check({tag, ".valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, ".error"}, {31'h0, resp_error}, {31'h0, got.err});
    check({tag, ".data"}, resp_data, got.data);
    check({tag, ".latency"}, lat, got.lat);
    check({tag, ".we_cycles"}, we_cnt - we_base, got.we);
    @(posedge clock);
    #1;
    check({tag, ".pulse_end"}, {31'h0, resp_valid}, 32'h0);
    check({tag, ".ready_after"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    pl_en          = 1'b0;
    pl_idx         = '0;
    pl_val         = '0;
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_size       = 2'b00;
    req_unsigned   = 1'b0;
    req_address    = '0;
    req_write_data = '0;

    preload(12'h041, 32'h8899AABB);
    preload(12'hFFF, 32'h01234567);
    #1;
    check("rst.ready", {31'h0, req_ready}, 32'h1);
    check("rst.valid", {31'h0, resp_valid}, 32'h0);
    check("rst.error", {31'h0, resp_error}, 32'h0);
    check("rst.data", resp_data, 32'h0);
    check("rst.ctl", {28'h0, ram_control}, 32'h0);
    check("rst.addr", ram_address, 32'h0);
    check("rst.wdata", ram_write_data, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Loads with extension.
    do_req("lb",  1'b0, 2'b00, 1'b0, 32'h105, 32'h0, 1'b0, 32'hFFFFFFAA, 2, 0);
    do_req("lbu", 1'b0, 2'b00, 1'b1, 32'h105, 32'h0, 1'b0, 32'h000000AA, 2, 0);
    do_req("lh",  1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 1'b0, 32'hFFFF8899, 2, 0);
    do_req("lhu", 1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 1'b0, 32'h00008899, 2, 0);
    do_req("lw",  1'b0, 2'b10, 1'b1, 32'h104, 32'h0, 1'b0, 32'h8899AABB, 2, 0);
    do_req("lb0", 1'b0, 2'b00, 1'b0, 32'h104, 32'h0, 1'b0, 32'hFFFFFFBB, 2, 0);
    do_req("lwmax", 1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, 1'b0, 32'h01234567, 2, 0);

    // Sub-word stores (read-modify-write).
    do_req("sb", 1'b1, 2'b00, 1'b0, 32'h107, 32'h00000012, 1'b0, 32'h0, 3, 1);
    check("sb.mem", mem[12'h041], 32'h1299AABB);
    do_req("sh", 1'b1, 2'b01, 1'b0, 32'h104, 32'h0000CAFE, 1'b0, 32'h0, 3, 1);
    check("sh.mem", mem[12'h041], 32'h1299CAFE);

    // Errors.
    do_req("e_lw_mis", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 1, 0);
    do_req("e_lh_mis", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 1, 0);
    do_req("e_size",   1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0);
    do_req("e_sw_rng", 1'b1, 2'b10, 1'b0, 32'h4000, 32'h55555555, 1'b1, 32'h0, 1, 0);
    do_req("e_sb_mis", 1'b1, 2'b10, 1'b0, 32'h105, 32'h77777777, 1'b1, 32'h0, 1, 0);
    check("err.mem", mem[12'h041], 32'h1299CAFE);

    // Word store interrupted by reset while in WRITE.
    @(negedge clock);
    req_valid      = 1'b1;
    req_write      = 1'b1;
    req_size       = 2'b10;
    req_unsigned   = 1'b0;
    req_address    = 32'h104;
    req_write_data = 32'hDEADBEEF;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    check("rw.we_on", {31'h0, ram_control[0]}, 32'h1);
    check("rw.wdata", ram_write_data, 32'hDEADBEEF);
    #2;
    reset_n = 1'b0;
    #1;
    check("rw.ctl", {28'h0, ram_control}, 32'h0);
    check("rw.ready", {31'h0, req_ready}, 32'h1);
    check("rw.valid", {31'h0, resp_valid}, 32'h0);
    check("rw.data", resp_data, 32'h0);
    check("rw.addr", ram_address, 32'h0);
    check("rw.wd0", ram_write_data, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rw.mem", mem[12'h041], 32'h1299CAFE);
    check("rw.ready2", {31'h0, req_ready}, 32'h1);

    do_req("post", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b0, 32'h1299CAFE, 2, 0);
    do_req("sw", 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1);
    check("sw.mem", mem[12'h041], 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
